// File: rtl/box_overlay_pkg.sv
// Shared definitions for the multi-box outline overlay.
//   - geometry/pixel widths and box-slot count
//   - box_t: one entry of the box list {valid, x, y, w, h, color}
//   - helpers: effective line thickness and 50% per-channel blend
package box_overlay_pkg;

    localparam int NUM_BOX   = 8;
    localparam int W_PW      = 11;
    localparam int W_PH      = 11;
    localparam int W_PIX     = 24;
    localparam int THICK_MAX = 4;

    localparam int W_IDX = $clog2(NUM_BOX);
    localparam int W_T   = $clog2(THICK_MAX + 1);

    typedef struct packed {
        logic             valid;
        logic [W_PW:0]    x;
        logic [W_PH:0]    y;
        logic [W_PW:0]    w;
        logic [W_PH:0]    h;
        logic [W_PIX-1:0] color;
    } box_t;

    // Zero thickness would make inner == outer and hide the box, so it maps to 1.
    function automatic logic [W_T-1:0] eff_thick(input logic [W_T-1:0] t);
        if (t == '0) begin
            return W_T'(1);
        end else if (t > W_T'(THICK_MAX)) begin
            return W_T'(THICK_MAX);
        end
        return t;
    endfunction

    // Halving each operand first keeps the sum inside 8 bits (max 127+127).
    function automatic logic [7:0] blend_ch(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a[7:1]} + {1'b0, b[7:1]};
    endfunction

    function automatic logic [W_PIX-1:0] blend_pix(input logic [W_PIX-1:0] a,
                                                   input logic [W_PIX-1:0] b);
        logic [W_PIX-1:0] r;
        r = '0;
        for (int c = 0; c < W_PIX / 8; c++) begin
            r[c*8 +: 8] = blend_ch(a[c*8 +: 8], b[c*8 +: 8]);
        end
        return r;
    endfunction

endpackage

// File: rtl/box_overlay_multi_hit.sv
// box_hit_test: registered outline test for a single box.
//   clk, rst          : clock, synchronous active-high reset
//   valid,x,y,w,h     : box geometry (right col = x+w, bottom row = y+h)
//   thick             : effective line thickness (already 1..THICK_MAX)
//   cnt_h, cnt_v      : column/row of the pixel currently in stage 1
//   hit_q             : registered "pixel lies on this box outline"
module box_hit_test
    import box_overlay_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           valid,
    input  logic [W_PW:0]  x,
    input  logic [W_PH:0]  y,
    input  logic [W_PW:0]  w,
    input  logic [W_PH:0]  h,
    input  logic [W_T-1:0] thick,
    input  logic [W_PW:0]  cnt_h,
    input  logic [W_PH:0]  cnt_v,
    output logic           hit_q
);

    // Wide enough for x+w without wrap plus a sign bit for x1-t going negative.
    localparam int W_C = ((W_PW > W_PH) ? W_PW : W_PH) + 4;

    logic signed [W_C-1:0] ph, pv, t, x0, x1, y0, y1;
    logic signed [W_C-1:0] ix0, ix1, iy0, iy1;
    logic                  outer, inner;
    logic                  hit_d;

    always_comb begin
        ph  = $signed(W_C'(cnt_h));
        pv  = $signed(W_C'(cnt_v));
        t   = $signed(W_C'(thick));
        x0  = $signed(W_C'(x));
        y0  = $signed(W_C'(y));
        x1  = x0 + $signed(W_C'(w));
        y1  = y0 + $signed(W_C'(h));
        ix0 = x0 + t;
        ix1 = x1 - t;
        iy0 = y0 + t;
        iy1 = y1 - t;
        outer = (ph >= x0) && (ph <= x1) && (pv >= y0) && (pv <= y1);
        // An inverted inner range (2t > w or 2t > h) matches nothing: solid box.
        inner = (ph >= ix0) && (ph <= ix1) && (pv >= iy0) && (pv <= iy1);
        hit_d = valid && outer && !inner;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

endmodule

// File: rtl/box_overlay_multi.sv
// box_overlay_multi: draws up to NUM_BOX rectangle outlines on a video stream.
//   clk, rst                      : clock, synchronous active-high reset
//   box_we/box_idx/box_valid/...  : write one slot of the shadow box list
//   thick, blend                  : line thickness / blend mode, taken at commit
//   vsync/hsync/de/pix            : video in
//   vsync_o/hsync_o/de_o/pix_o    : video out, 3 cycles later
//   hit_o, hit_idx_o              : output pixel is on an outline / winning slot
// The shadow list is copied into the active list on each input vsync rise,
// so boxes only change between frames.
module box_overlay_multi
    import box_overlay_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             box_we,
    input  logic [W_IDX-1:0] box_idx,
    input  logic             box_valid,
    input  logic [W_PW:0]    box_x,
    input  logic [W_PH:0]    box_y,
    input  logic [W_PW:0]    box_w,
    input  logic [W_PH:0]    box_h,
    input  logic [W_PIX-1:0] box_color,
    input  logic [W_T-1:0]   thick,
    input  logic             blend,
    input  logic             vsync,
    input  logic             hsync,
    input  logic             de,
    input  logic [W_PIX-1:0] pix,
    output logic             vsync_o,
    output logic             hsync_o,
    output logic             de_o,
    output logic [W_PIX-1:0] pix_o,
    output logic             hit_o,
    output logic [W_IDX-1:0] hit_idx_o
);

    localparam logic [W_PW:0] ONE_H = 1;
    localparam logic [W_PH:0] ONE_V = 1;

    // ---------------- stage 1: counters and input registers ----------------
    logic             vs_s1_q, hs_s1_q, de_s1_q;
    logic [W_PIX-1:0] pix_s1_q;
    logic [W_PW:0]    cnt_h_s1_q, h_cnt_q, h_cnt_d;
    logic [W_PH:0]    cnt_v_s1_q, v_cnt_q, v_cnt_d;
    logic             commit;

    // vs_s1_q / de_s1_q double as the one-cycle-old copies for edge detection.
    assign commit = vsync & ~vs_s1_q;

    always_comb begin
        h_cnt_d = de ? (h_cnt_q + ONE_H) : '0;
        v_cnt_d = v_cnt_q;
        if (commit) begin
            v_cnt_d = '0;
        end else if (de_s1_q && !de && (v_cnt_q != '1)) begin
            v_cnt_d = v_cnt_q + ONE_V;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b0;
            de_s1_q    <= 1'b0;
            pix_s1_q   <= '0;
            cnt_h_s1_q <= '0;
            cnt_v_s1_q <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
        end else begin
            vs_s1_q    <= vsync;
            hs_s1_q    <= hsync;
            de_s1_q    <= de;
            pix_s1_q   <= pix;
            cnt_h_s1_q <= h_cnt_q;   // column of this pixel = earlier de cycles
            cnt_v_s1_q <= v_cnt_q;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
        end
    end

    // ---------------- commit-latched settings ----------------
    logic [W_T-1:0] thick_act_q, thick_act_d;
    logic           blend_act_q, blend_act_d;

    always_comb begin
        thick_act_d = commit ? eff_thick(thick) : thick_act_q;
        blend_act_d = commit ? blend : blend_act_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thick_act_q <= W_T'(1);
            blend_act_q <= 1'b0;
        end else begin
            thick_act_q <= thick_act_d;
            blend_act_q <= blend_act_d;
        end
    end

    // ---------------- box slots + stage 2 compare ----------------
    logic [NUM_BOX-1:0]             hit_s2;
    logic [NUM_BOX-1:0][W_PIX-1:0]  color_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOX; gi++) begin : g_slot
            box_t shadow_q, shadow_d, active_q, active_d;

            // The commit copies shadow_q, so a same-cycle write lands in the
            // shadow only and reaches the active list one frame later.
            always_comb begin
                shadow_d = shadow_q;
                if (box_we && (box_idx == W_IDX'(gi))) begin
                    shadow_d = {box_valid, box_x, box_y, box_w, box_h, box_color};
                end
                active_d = commit ? shadow_q : active_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q <= '0;
                    active_q <= '0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                end
            end

            box_hit_test u_hit (
                .clk   (clk),
                .rst   (rst),
                .valid (active_q.valid),
                .x     (active_q.x),
                .y     (active_q.y),
                .w     (active_q.w),
                .h     (active_q.h),
                .thick (thick_act_q),
                .cnt_h (cnt_h_s1_q),
                .cnt_v (cnt_v_s1_q),
                .hit_q (hit_s2[gi])
            );

            assign color_vec[gi] = active_q.color;
        end
    endgenerate

    logic             vs_s2_q, hs_s2_q, de_s2_q;
    logic [W_PIX-1:0] pix_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s2_q  <= 1'b0;
            hs_s2_q  <= 1'b0;
            de_s2_q  <= 1'b0;
            pix_s2_q <= '0;
        end else begin
            vs_s2_q  <= vs_s1_q;
            hs_s2_q  <= hs_s1_q;
            de_s2_q  <= de_s1_q;
            pix_s2_q <= pix_s1_q;
        end
    end

    // ---------------- stage 3: priority encode and colour mux ----------------
    logic             win_hit;
    logic [W_IDX-1:0] win_idx;
    logic [W_PIX-1:0] win_color;
    logic             vs_s3_q, hs_s3_q, de_s3_q, hit_s3_q;
    logic [W_PIX-1:0] pix_s3_q, pix_s3_d;
    logic [W_IDX-1:0] idx_s3_q, idx_s3_d;
    logic             hit_s3_d;

    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        // Scan downward so the lowest hitting slot is the one left standing.
        for (int i = NUM_BOX - 1; i >= 0; i--) begin
            if (hit_s2[i]) begin
                win_hit = 1'b1;
                win_idx = W_IDX'(i);
            end
        end
        win_color = color_vec[win_idx];

        pix_s3_d = pix_s2_q;
        hit_s3_d = 1'b0;
        idx_s3_d = '0;
        if (de_s2_q && win_hit) begin
            hit_s3_d = 1'b1;
            idx_s3_d = win_idx;
            pix_s3_d = blend_act_q ? blend_pix(pix_s2_q, win_color) : win_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s3_q  <= 1'b0;
            hs_s3_q  <= 1'b0;
            de_s3_q  <= 1'b0;
            pix_s3_q <= '0;
            hit_s3_q <= 1'b0;
            idx_s3_q <= '0;
        end else begin
            vs_s3_q  <= vs_s2_q;
            hs_s3_q  <= hs_s2_q;
            de_s3_q  <= de_s2_q;
            pix_s3_q <= pix_s3_d;
            hit_s3_q <= hit_s3_d;
            idx_s3_q <= idx_s3_d;
        end
    end

    assign vsync_o   = vs_s3_q;
    assign hsync_o   = hs_s3_q;
    assign de_o      = de_s3_q;
    assign pix_o     = pix_s3_q;
    assign hit_o     = hit_s3_q;
    assign hit_idx_o = idx_s3_q;

endmodule

// File: tb/tb_box_overlay_multi.sv
// Bench for box_overlay_multi: streams 64x32 frames, checks sync/blanking
// pass-through on every cycle against a 3-deep input history, and checks a
// table of hand-computed probe pixels per frame.
module tb_box_overlay_multi;
    import box_overlay_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             box_we;
    logic [W_IDX-1:0] box_idx;
    logic             box_valid;
    logic [W_PW:0]    box_x, box_w;
    logic [W_PH:0]    box_y, box_h;
    logic [W_PIX-1:0] box_color;
    logic [W_T-1:0]   thick;
    logic             blend;
    logic             vsync, hsync, de;
    logic [W_PIX-1:0] pix;
    logic             vsync_o, hsync_o, de_o, hit_o;
    logic [W_PIX-1:0] pix_o;
    logic [W_IDX-1:0] hit_idx_o;

    always #5 clk = ~clk;

    box_overlay_multi dut (
        .clk(clk), .rst(rst), .box_we(box_we), .box_idx(box_idx),
        .box_valid(box_valid), .box_x(box_x), .box_y(box_y), .box_w(box_w),
        .box_h(box_h), .box_color(box_color), .thick(thick), .blend(blend),
        .vsync(vsync), .hsync(hsync), .de(de), .pix(pix),
        .vsync_o(vsync_o), .hsync_o(hsync_o), .de_o(de_o), .pix_o(pix_o),
        .hit_o(hit_o), .hit_idx_o(hit_idx_o)
    );

    typedef struct {
        int          tag;
        int          col;
        int          row;
        bit          hit;
        logic [2:0]  idx;
        logic [23:0] pix;
    } probe_t;

    typedef struct {
        bit          vs;
        bit          hs;
        bit          de;
        logic [23:0] pix;
        int          tag;
        int          col;
        int          row;
    } hist_t;

    probe_t probes[$];
    hist_t  hist[3];
    int     n_tests = 0;
    int     n_fail = 0;
    int     n_probe_seen = 0;

    function automatic logic [23:0] pat(input int c, input int r);
        logic [7:0] a, b;
        a = 8'(c * 3);
        b = 8'(r * 5);
        return {a, b, 8'hA5};
    endfunction

    function automatic void add(input int tag, input int c, input int r,
                                input bit hit, input int idx, input logic [23:0] color);
        probe_t p;
        p.tag = tag; p.col = c; p.row = r; p.hit = hit; p.idx = 3'(idx);
        p.pix = hit ? color : pat(c, r);
        probes.push_back(p);
    endfunction

    function automatic void addf(input int tag, input int c, input int r,
                                 input bit hit, input int idx, input logic [23:0] v);
        probe_t p;
        p.tag = tag; p.col = c; p.row = r; p.hit = hit; p.idx = 3'(idx); p.pix = v;
        probes.push_back(p);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) hist[i] = '{vs:0, hs:0, de:0, pix:24'h0, tag:-1, col:-1, row:-1};
    endtask

    // One clock: check outputs against inputs driven three steps ago, then drive.
    task automatic step(input bit vs, input bit hs, input bit d, input logic [23:0] p,
                        input int tag, input int col, input int row, input bit we);
        hist_t e;
        @(posedge clk);
        #1;
        e = hist[2];
        n_tests++;
        if ({vsync_o, hsync_o, de_o} !== {e.vs, e.hs, e.de}) begin
            n_fail++;
            $display("FAIL sync t=%0d c=%0d r=%0d actual=%b%b%b required=%b%b%b",
                     e.tag, e.col, e.row, vsync_o, hsync_o, de_o, e.vs, e.hs, e.de);
        end
        if (!e.de) begin
            n_tests++;
            if (pix_o !== e.pix || hit_o !== 1'b0) begin
                n_fail++;
                $display("FAIL blank t=%0d actual pix=%h hit=%b required pix=%h hit=0",
                         e.tag, pix_o, hit_o, e.pix);
            end
        end else if (e.tag >= 0) begin
            foreach (probes[i]) begin
                if (probes[i].tag == e.tag && probes[i].col == e.col && probes[i].row == e.row) begin
                    n_tests++;
                    n_probe_seen++;
                    if (pix_o !== probes[i].pix || hit_o !== probes[i].hit ||
                        (probes[i].hit && hit_idx_o !== probes[i].idx)) begin
                        n_fail++;
                        $display("FAIL probe f%0d (%0d,%0d) actual pix=%h hit=%b idx=%0d required pix=%h hit=%b idx=%0d",
                                 e.tag, e.col, e.row, pix_o, hit_o, hit_idx_o,
                                 probes[i].pix, probes[i].hit, probes[i].idx);
                    end
                end
            end
        end
        vsync = vs; hsync = hs; de = d; pix = p; box_we = we;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{vs:vs, hs:hs, de:d, pix:p, tag:tag, col:col, row:row};
    endtask

    task automatic set_box(input int idx, input bit v, input int x, input int y,
                           input int w, input int h, input logic [23:0] c);
        box_idx = 3'(idx); box_valid = v; box_x = 12'(x); box_y = 12'(y);
        box_w = 12'(w); box_h = 12'(h); box_color = c;
    endtask

    task automatic write_box(input int idx, input bit v, input int x, input int y,
                             input int w, input int h, input logic [23:0] c);
        set_box(idx, v, x, y, w, h, c);
        step(0, 0, 0, 24'h0, -1, -1, -1, 1);
        step(0, 0, 0, 24'h0, -1, -1, -1, 0);
    endtask

    // 64x32 active picture, 2 vsync cycles, 3 idle, 4 blanking cycles per line.
    task automatic run_frame(input int tag, input bit flat, input bit wr_mid, input bit wr_vs);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 24'h0, tag, -1, -1, (i == 0) && wr_vs);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 24'h0, tag, -1, -1, 0);
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 68; c++) begin
                if (c < 64) begin
                    step(0, 0, 1, flat ? 24'h808080 : pat(c, r), tag, c, r,
                         wr_mid && (r == 2) && (c == 0));
                end else begin
                    step(0, (c == 65) || (c == 66), 0, 24'h0, tag, -1, -1, 0);
                end
            end
        end
        step(0, 0, 0, 24'h0, -1, -1, -1, 0);
    endtask

    initial begin
        // frame 1: thin red outline
        add(1, 10, 5, 1, 0, 24'hFF0000);  add(1, 20, 5, 1, 0, 24'hFF0000);
        add(1, 30, 5, 1, 0, 24'hFF0000);  add(1, 31, 5, 0, 0, 0);
        add(1, 9, 5, 0, 0, 0);            add(1, 20, 15, 1, 0, 24'hFF0000);
        add(1, 10, 10, 1, 0, 24'hFF0000); add(1, 30, 10, 1, 0, 24'hFF0000);
        add(1, 11, 10, 0, 0, 0);          add(1, 29, 6, 0, 0, 0);
        add(1, 20, 4, 0, 0, 0);           add(1, 20, 16, 0, 0, 0);
        add(1, 10, 16, 0, 0, 0);          add(1, 30, 15, 1, 0, 24'hFF0000);
        // frame 2: thickness 3
        add(2, 20, 7, 1, 0, 24'hFF0000);  add(2, 20, 8, 0, 0, 0);
        add(2, 20, 13, 1, 0, 24'hFF0000); add(2, 12, 10, 1, 0, 24'hFF0000);
        add(2, 13, 10, 0, 0, 0);          add(2, 28, 10, 1, 0, 24'hFF0000);
        add(2, 27, 10, 0, 0, 0);          add(2, 9, 10, 0, 0, 0);
        add(2, 31, 10, 0, 0, 0);
        // frame 3: w=4, t=3 -> solid
        add(3, 12, 10, 1, 0, 24'hFF0000); add(3, 11, 9, 1, 0, 24'hFF0000);
        add(3, 14, 10, 1, 0, 24'hFF0000); add(3, 15, 10, 0, 0, 0);
        add(3, 12, 4, 0, 0, 0);
        // frame 4: priority slot2 over slot5
        add(4, 12, 5, 1, 2, 24'h0000FF);  add(4, 6, 5, 1, 5, 24'h00FF00);
        add(4, 12, 10, 1, 2, 24'h0000FF); add(4, 25, 10, 1, 5, 24'h00FF00);
        add(4, 22, 10, 1, 2, 24'h0000FF); add(4, 15, 10, 0, 0, 0);
        // frame 5: slot2 invalidated
        add(5, 12, 5, 1, 5, 24'h00FF00);  add(5, 12, 10, 0, 0, 0);
        add(5, 22, 10, 0, 0, 0);          add(5, 6, 5, 1, 5, 24'h00FF00);
        // frame 6: blend on flat grey
        addf(6, 10, 5, 1, 0, 24'hBF4040); addf(6, 30, 15, 1, 0, 24'hBF4040);
        addf(6, 11, 10, 0, 0, 24'h808080); addf(6, 20, 20, 0, 0, 24'h808080);
        // frame 7: mid-frame write does not affect current frame
        add(7, 10, 5, 1, 0, 24'hFF0000);  add(7, 20, 15, 1, 0, 24'hFF0000);
        add(7, 40, 20, 0, 0, 0);
        // frame 8: pre-write shadow (green) despite write in the vsync cycle
        add(8, 40, 20, 1, 0, 24'h00FF00); add(8, 45, 25, 1, 0, 24'h00FF00);
        add(8, 42, 22, 0, 0, 0);          add(8, 10, 5, 0, 0, 0);
        add(8, 50, 2, 0, 0, 0);
        // frame 9: new value (blue)
        add(9, 50, 2, 1, 0, 24'h0000FF);  add(9, 56, 8, 1, 0, 24'h0000FF);
        add(9, 40, 20, 0, 0, 0);
        // frame 10: clipped box, thick=0 treated as 1
        add(10, 60, 8, 1, 0, 24'hFFFF00); add(10, 63, 8, 1, 0, 24'hFFFF00);
        add(10, 63, 12, 1, 0, 24'hFFFF00); add(10, 60, 10, 1, 0, 24'hFFFF00);
        add(10, 61, 10, 0, 0, 0);         add(10, 63, 10, 0, 0, 0);
        add(10, 0, 8, 0, 0, 0);           add(10, 0, 10, 0, 0, 0);
        add(10, 16, 8, 0, 0, 0);          add(10, 16, 12, 0, 0, 0);
        add(10, 59, 8, 0, 0, 0);
        // frame 11: after reset, nothing drawn
        add(11, 60, 8, 0, 0, 0);          add(11, 63, 8, 0, 0, 0);
        add(11, 60, 10, 0, 0, 0);
        // frame 12: rewritten, thick=7 clamped to 4
        add(12, 30, 10, 0, 0, 0);         add(12, 30, 7, 1, 0, 24'h00FFFF);
        add(12, 30, 4, 1, 0, 24'h00FFFF); add(12, 23, 10, 1, 0, 24'h00FFFF);
        add(12, 24, 10, 0, 0, 0);         add(12, 20, 16, 1, 0, 24'h00FFFF);
        add(12, 40, 8, 1, 0, 24'h00FFFF); add(12, 36, 10, 0, 0, 0);
        add(12, 37, 10, 1, 0, 24'h00FFFF);

        rst = 1'b1; box_we = 0; thick = 3'd1; blend = 0;
        vsync = 0; hsync = 0; de = 0; pix = 24'h0;
        set_box(0, 0, 0, 0, 0, 0, 24'h0);
        clear_hist();
        repeat (3) @(posedge clk);
        #1;
        chk("reset vsync_o", 32'(vsync_o), 0);
        chk("reset de_o", 32'(de_o), 0);
        chk("reset pix_o", 32'(pix_o), 0);
        chk("reset hit_o", 32'(hit_o), 0);
        chk("reset hit_idx_o", 32'(hit_idx_o), 0);
        rst = 1'b0;

        // Test 1
        write_box(0, 1, 10, 5, 20, 10, 24'hFF0000);
        run_frame(1, 0, 0, 0);
        // Test 2
        thick = 3'd3;
        run_frame(2, 0, 0, 0);
        write_box(0, 1, 10, 5, 4, 10, 24'hFF0000);
        run_frame(3, 0, 0, 0);
        // Test 3
        thick = 3'd1;
        write_box(0, 0, 10, 5, 4, 10, 24'hFF0000);
        write_box(2, 1, 12, 5, 10, 10, 24'h0000FF);
        write_box(5, 1, 5, 5, 20, 10, 24'h00FF00);
        run_frame(4, 0, 0, 0);
        write_box(2, 0, 12, 5, 10, 10, 24'h0000FF);
        run_frame(5, 0, 0, 0);
        // Test 4
        write_box(5, 0, 5, 5, 20, 10, 24'h00FF00);
        write_box(0, 1, 10, 5, 20, 10, 24'hFF0000);
        blend = 1;
        run_frame(6, 1, 0, 0);
        // Test 5
        blend = 0;
        set_box(0, 1, 40, 20, 5, 5, 24'h00FF00);
        run_frame(7, 0, 1, 0);
        set_box(0, 1, 50, 2, 6, 6, 24'h0000FF);
        run_frame(8, 0, 0, 1);
        run_frame(9, 0, 0, 0);
        // Test 6: clipping
        thick = 3'd0;
        write_box(0, 1, 60, 8, 20, 4, 24'hFFFF00);
        run_frame(10, 0, 0, 0);
        // reset in the middle of an active line
        for (int c = 0; c < 10; c++) step(0, 0, 1, pat(c, 3), -1, c, 3, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst vsync_o", 32'(vsync_o), 0);
        chk("midrst hsync_o", 32'(hsync_o), 0);
        chk("midrst de_o", 32'(de_o), 0);
        chk("midrst pix_o", 32'(pix_o), 0);
        chk("midrst hit_o", 32'(hit_o), 0);
        chk("midrst hit_idx_o", 32'(hit_idx_o), 0);
        vsync = 0; hsync = 0; de = 0; pix = 24'h0; box_we = 0;
        clear_hist();
        rst = 1'b0;
        thick = 3'd7;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 24'h0, -1, -1, -1, 0);
        run_frame(11, 0, 0, 0);
        write_box(0, 1, 20, 4, 20, 12, 24'h00FFFF);
        run_frame(12, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 24'h0, -1, -1, -1, 0);

        chk("probes seen", n_probe_seen, probes.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
